// File: rtl/vga_pkg.sv
// Shared timing constants, pixel/colour types and test-bar palette for the VGA timing generator.
// Optional build macro VGA_TEST_PATTERN_EN selects the built-in colour-bar source.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int BAR_WIDTH = 80;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BAR_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t BAR_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t BAR_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_t BAR_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t BAR_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
  localparam rgb_t BAR_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t BAR_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_t BAR_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};

  function automatic rgb_t test_bar_colour(input coord_t x);
    coord_t bar;
    bar = x / coord_t'(BAR_WIDTH);
    case (bar)
      10'd0:   test_bar_colour = BAR_WHITE;
      10'd1:   test_bar_colour = BAR_YELLOW;
      10'd2:   test_bar_colour = BAR_CYAN;
      10'd3:   test_bar_colour = BAR_GREEN;
      10'd4:   test_bar_colour = BAR_MAGENTA;
      10'd5:   test_bar_colour = BAR_RED;
      10'd6:   test_bar_colour = BAR_BLUE;
      default: test_bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate interface between the timing generator (master) and a colour mapper (slave).
interface vga_timing_gen_if;
  import vga_pkg::coord_t;

  coord_t     DrawX;
  coord_t     DrawY;
  logic       pixel_ce;
  logic       frame_start;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;

  modport master (
    output DrawX, DrawY, pixel_ce, frame_start,
    input  Red, Green, Blue
  );

  modport slave (
    input  DrawX, DrawY, pixel_ce, frame_start,
    output Red, Green, Blue
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: enabled wrap-around counter with wrap flag, sync-window and visible-region decode.
module vga_axis_counter
  import vga_pkg::coord_t;
#(
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   en,
  output coord_t cnt,
  output logic   wrap,
  output logic   in_sync,
  output logic   visible
);

  coord_t cnt_q;
  coord_t cnt_d;

  assign wrap    = (cnt_q == coord_t'(TOTAL - 1));
  assign in_sync = (cnt_q >= coord_t'(SYNC_START)) && (cnt_q < coord_t'(SYNC_END));
  assign visible = (cnt_q < coord_t'(VISIBLE));
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (wrap) begin
        cnt_d = 10'd0;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 10'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel-rate divider, H/V counters, registered sync/blank/RGB to the DAC.
// Define VGA_TEST_PATTERN_EN to replace the RGB inputs with eight built-in colour bars.
module vga_timing_gen
  import vga_pkg::coord_t;
  import vga_pkg::rgb_t;
  import vga_pkg::test_bar_colour;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master px,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pixel_ce_s;
  coord_t           h_cnt_s, v_cnt_s;
  logic             h_wrap_s, v_wrap_s;
  logic             h_sync_s, v_sync_s;
  logic             h_vis_s, v_vis_s;
  rgb_t             rgb_src_s;
  rgb_t             rgb_q, rgb_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

  assign pixel_ce_s = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (pixel_ce_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FP), .SYNC_END(H_VISIBLE + H_FP + H_SYNC)
  ) u_h (
    .Clk(Clk), .Reset(Reset), .en(pixel_ce_s),
    .cnt(h_cnt_s), .wrap(h_wrap_s), .in_sync(h_sync_s), .visible(h_vis_s)
  );

  // Vertical steps once per line, so it also wraps on the same strobe as the horizontal counter.
  vga_axis_counter #(
    .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FP), .SYNC_END(V_VISIBLE + V_FP + V_SYNC)
  ) u_v (
    .Clk(Clk), .Reset(Reset), .en(pixel_ce_s & h_wrap_s),
    .cnt(v_cnt_s), .wrap(v_wrap_s), .in_sync(v_sync_s), .visible(v_vis_s)
  );

  always_comb begin
`ifdef VGA_TEST_PATTERN_EN
    rgb_src_s = test_bar_colour(h_cnt_s);
`else
    rgb_src_s = rgb_t'({px.Red, px.Green, px.Blue});
`endif
  end

  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pixel_ce_s) begin
      hs_d      = ~h_sync_s;
      vs_d      = ~v_sync_s;
      blank_n_d = h_vis_s & v_vis_s;
      if (h_vis_s & v_vis_s) begin
        rgb_d = rgb_src_s;
      end else begin
        rgb_d = 24'h000000;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= 24'h000000;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign px.DrawX       = h_cnt_s;
  assign px.DrawY       = v_cnt_s;
  assign px.pixel_ce    = pixel_ce_s;
  assign px.frame_start = pixel_ce_s & (h_cnt_s == 10'd0) & (v_cnt_s == 10'd0);

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;

  // v_wrap is implied by the h/v counts; kept for visibility in waveforms.
  logic unused_s;
  assign unused_s = v_wrap_s;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/line behaviour, shrunken CLK_DIV=1 instance for frame behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  vga_timing_gen_if pa ();
  vga_timing_gen_if pb ();

  logic a_hs, a_vs, a_bn, a_sn;
  logic [7:0] a_r, a_g, a_b;
  logic b_hs, b_vs, b_bn, b_sn;
  logic [7:0] b_r, b_g, b_b;

  vga_timing_gen #(.CLK_DIV(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .px(pa.master),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
  );

  // Small raster: H 8+2+3+2=15, V 6+1+2+1=10, hsync x=10..12, vsync y=7..8.
  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .px(pb.master),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
  );

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / 80)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(input int x, input int y, input int hv, input int vv);
    if (x < hv && y < vv) return TP ? bar_rgb(x) : 24'hAB1234;
    return 24'h000000;
  endfunction

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int n = 0;
    pa.Red = 8'hAB; pa.Green = 8'h12; pa.Blue = 8'h34;
    apply_reset();
    while (pa.DrawX != 10'd300 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (pa.DrawX != 10'd300) begin
      failures++;
      $display("FAIL reach_h300 DrawX=%0d required=300 after %0d cycles", pa.DrawX, n);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (pa.DrawX !== 10'd0 || pa.DrawY !== 10'd0) begin
      failures++;
      $display("FAIL reset_coords DrawX=%0d DrawY=%0d required=0,0", pa.DrawX, pa.DrawY);
    end
    checks++;
    if ({a_hs, a_vs, a_bn, a_sn} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_sync hs,vs,blank_n,sync_n=%b required=1100", {a_hs, a_vs, a_bn, a_sn});
    end
    checks++;
    if ({a_r, a_g, a_b} !== 24'h000000) begin
      failures++;
      $display("FAIL reset_rgb rgb=%h required=000000", {a_r, a_g, a_b});
    end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (pa.pixel_ce !== 1'b0) begin
      failures++;
      $display("FAIL release_pce0 pixel_ce=%b required=0", pa.pixel_ce);
    end
    tick();
    checks++;
    if (pa.pixel_ce !== 1'b1 || pa.frame_start !== 1'b1) begin
      failures++;
      $display("FAIL first_pce pixel_ce=%b frame_start=%b required=1,1", pa.pixel_ce, pa.frame_start);
    end
  endtask

  task automatic test_line();
    int pce_cnt = 0, hs_low = 0, first_hs_x = -1, mism = 0, ex = 0;
    int lx = 0, ly = 0;
    logic pce_prev = 1'b0;
    logic [23:0] rgb0 = 24'hx, rgb80 = 24'hx, rgb560 = 24'hx, rgb640 = 24'hx;
    apply_reset();
    for (int i = 0; i < 1600; i++) begin
      if (pa.pixel_ce && !TP) begin
        pa.Red = 8'hAB; pa.Green = 8'h12; pa.Blue = 8'h34;
      end else begin
        pa.Red = 8'($urandom); pa.Green = 8'($urandom); pa.Blue = 8'($urandom);
      end
      tick();
      if (pce_prev) begin
        if (a_hs !== !(lx >= 656 && lx < 752)) mism++;
        if (a_vs !== 1'b1) mism++;
        if (a_bn !== (lx < 640 && ly < 480)) mism++;
        if ({a_r, a_g, a_b} !== exp_rgb(lx, ly, 640, 480)) mism++;
        if (a_hs === 1'b0) begin
          hs_low++;
          if (first_hs_x < 0) first_hs_x = lx;
        end
        if (lx == 0)   rgb0   = {a_r, a_g, a_b};
        if (lx == 80)  rgb80  = {a_r, a_g, a_b};
        if (lx == 560) rgb560 = {a_r, a_g, a_b};
        if (lx == 640) rgb640 = {a_r, a_g, a_b};
      end
      if (pa.pixel_ce) begin
        pce_cnt++;
        if (pa.DrawX != 10'(ex) || pa.DrawY != 10'd0) mism++;
        lx = int'(pa.DrawX);
        ly = int'(pa.DrawY);
        ex++;
      end
      pce_prev = pa.pixel_ce;
    end
    checks++;
    if (pce_cnt != 800) begin
      failures++;
      $display("FAIL line_pce_count got=%0d required=800", pce_cnt);
    end
    checks++;
    if (hs_low != 96) begin
      failures++;
      $display("FAIL line_hs_width got=%0d required=96", hs_low);
    end
    checks++;
    if (first_hs_x != 656) begin
      failures++;
      $display("FAIL line_hs_start got=%0d required=656", first_hs_x);
    end
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL line_model mismatches=%0d required=0", mism);
    end
    checks++;
    if (rgb0 !== exp_rgb(0, 0, 640, 480) || rgb80 !== exp_rgb(80, 0, 640, 480)) begin
      failures++;
      $display("FAIL rgb_h0_h80 got=%h,%h required=%h,%h", rgb0, rgb80,
               exp_rgb(0, 0, 640, 480), exp_rgb(80, 0, 640, 480));
    end
    checks++;
    if (rgb560 !== exp_rgb(560, 0, 640, 480)) begin
      failures++;
      $display("FAIL rgb_h560 got=%h required=%h", rgb560, exp_rgb(560, 0, 640, 480));
    end
    checks++;
    if (rgb640 !== 24'h000000) begin
      failures++;
      $display("FAIL rgb_h640_blank got=%h required=000000", rgb640);
    end
    checks++;
    if (pa.DrawX !== 10'd0 || pa.DrawY !== 10'd1) begin
      failures++;
      $display("FAIL line_wrap DrawX=%0d DrawY=%0d required=0,1", pa.DrawX, pa.DrawY);
    end
  endtask

  task automatic test_frame();
    int mism = 0, vs_low = 0, fs_cnt = 0, wrap_ok = 0, line_cnt = 0;
    int ex = 0, ey = 0, px_ = 0, py_ = 0;
    logic have_prev = 1'b0;
    pb.Red = 8'hAB; pb.Green = 8'h12; pb.Blue = 8'h34;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if (pb.pixel_ce !== 1'b1) mism++;
      if (pb.DrawX != 10'(ex) || pb.DrawY != 10'(ey)) mism++;
      if (pb.frame_start === 1'b1) fs_cnt++;
      if (pb.DrawX == 10'd0) line_cnt++;
      if (have_prev) begin
        if (b_hs !== !(px_ >= 10 && px_ < 13)) mism++;
        if (b_vs !== !(py_ >= 7 && py_ < 9)) mism++;
        if (b_bn !== (px_ < 8 && py_ < 6)) mism++;
        if ({b_r, b_g, b_b} !== exp_rgb(px_, py_, 8, 6)) mism++;
        if (b_vs === 1'b0) vs_low++;
        if (px_ == 14 && py_ == 9 && pb.DrawX == 10'd0 && pb.DrawY == 10'd0 && pb.frame_start === 1'b1)
          wrap_ok++;
      end
      px_ = int'(pb.DrawX);
      py_ = int'(pb.DrawY);
      have_prev = 1'b1;
      if (ex == 14) begin
        ex = 0;
        ey = (ey == 9) ? 0 : ey + 1;
      end else begin
        ex++;
      end
      if (TP) begin
        pb.Red = 8'($urandom); pb.Green = 8'($urandom); pb.Blue = 8'($urandom);
      end
      tick();
    end
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL frame_model mismatches=%0d required=0", mism);
    end
    checks++;
    if (vs_low != 60) begin
      failures++;
      $display("FAIL frame_vs_width got=%0d required=60", vs_low);
    end
    checks++;
    if (fs_cnt != 2) begin
      failures++;
      $display("FAIL frame_start_count got=%0d required=2", fs_cnt);
    end
    checks++;
    if (wrap_ok != 1) begin
      failures++;
      $display("FAIL frame_wrap got=%0d required=1", wrap_ok);
    end
    checks++;
    if (line_cnt != 20) begin
      failures++;
      $display("FAIL frame_lines got=%0d required=20", line_cnt);
    end
  endtask

  initial begin
    pa.Red = 8'h00; pa.Green = 8'h00; pa.Blue = 8'h00;
    pb.Red = 8'h00; pb.Green = 8'h00; pb.Blue = 8'h00;
    @(negedge Clk);
    test_reset();
    test_line();
    test_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the pixel-coordinate interface.
- Divides the system clock down to the pixel rate and runs horizontal/vertical counters for 640x480@60.
- Drives DrawX/DrawY to the downstream colour mapper and samples the combinational RGB it returns.
- Registers RGB aligned with HS/VS/BLANK toward the VGA DAC, so colour and sync leave the block on the same cycle.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); must be >= 1
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Red  in  8  colour for current DrawX/DrawY, from colour mapper
- Green  in  8  see Red
- Blue  in  8  see Red
- DrawX  out  10  current horizontal count (0..H_TOTAL-1)
- DrawY  out  10  current vertical count (0..V_TOTAL-1)
- pixel_ce  out  1  one-Clk strobe marking the last Clk of each pixel period
- frame_start  out  1  one-Clk pulse on pixel_ce at DrawX=0, DrawY=0
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high in visible region
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- VGA_R  out  8  registered red
- VGA_G  out  8  registered green
- VGA_B  out  8  registered blue

Behaviour:
- Totals:
  - H_TOTAL = sum of the H_* parameters (800).
  - V_TOTAL = sum of the V_* parameters (525).
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 each Clk, then wraps.
  - pixel_ce = (div_cnt == CLK_DIV-1).
  - With CLK_DIV=1, pixel_ce is constantly high.
- Horizontal counter:
  - h_cnt advances only on pixel_ce.
  - At H_TOTAL-1 it wraps to 0 and asserts line_end.
- Vertical counter:
  - v_cnt advances on pixel_ce & line_end.
  - At V_TOTAL-1 it wraps to 0.
  - Simultaneous h and v wrap at (799,524) → (0,0) on the same pixel_ce.
- DrawX/DrawY:
  - Driven directly from h_cnt/v_cnt.
  - Stable for all CLK_DIV cycles of a pixel.
  - The combinational colour mapper settles within that pixel.
- Output register (updates only on pixel_ce, 1-pixel latency relative to DrawX/DrawY):
  - VGA_HS = 0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491).
  - VGA_BLANK_N = (h_cnt < H_VISIBLE) & (v_cnt < V_VISIBLE).
  - VGA_R/G/B = Red/Green/Blue when visible, else 8'h00 (DAC sees black in blanking).
- frame_start: combinational = pixel_ce & (h_cnt==0) & (v_cnt==0).
- Reset (async, any time including mid-frame):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
  - First pixel_ce after release is Clk cycle CLK_DIV-1.
- Inputs Red/Green/Blue are sampled only on pixel_ce; changes between strobes are ignored.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: RGB inputs are ignored. Visible region shows 8 vertical bars of 80 pixels, selected by h_cnt[9:7]... more precisely bar = h_cnt/80:
  - Colours in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is 8'hFF or 8'h00.
  - Timing and blanking are unchanged.
- Undefined: normal pass-through as specified above.

Decomposition:
- Package vga_pkg holds:
  - timing constants (H_VISIBLE..V_BP, H_TOTAL, V_TOTAL);
  - typedef coord_t (logic [9:0]);
  - typedef struct rgb_t {r,g,b: logic [7:0]};
  - test-bar colour constants.
- One natural sub-module: vga_axis_counter, instantiated twice.
  - Generic: count with enable, wrap at TOTAL-1, wrap flag output, sync-window compare.
  - Instance 1: h, enabled by pixel_ce.
  - Instance 2: v, enabled by pixel_ce & h wrap.

Test Plan:
- Reset asserted mid-line at h=300 → within the same Clk, DrawX=0, DrawY=0, HS=VS=1, BLANK_N=0, RGB=0.
- Run one full line, CLK_DIV=2 → exactly 800 pixel_ce pulses in 1600 Clk; HS low for 96 pixels starting with the registered output of h=656.
- Run a full frame → 525 lines; VS low for exactly 2 lines (v=490,491); frame_start pulses once per 420000 pixel_ce.
- Hold Red=8'hAB, Green=8'h12, Blue=8'h34:
  - VGA_R/G/B = AB/12/34 one pixel after h=0..639, v<480.
  - 00/00/00 at h=640 and at v=480.
- Wrap at (799,524) → next pixel_ce gives DrawX=0, DrawY=0 with frame_start=1.
- With VGA_TEST_PATTERN_EN defined and RGB inputs toggling randomly:
  - h=0 → FFFFFF; h=80 → FFFF00; h=560 → 000000.
  - Blanking is unchanged.
